// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_arbiter
// Description : Two-port fixed-priority arbiter and SPI mode-0 READ sequencer
//               for a W25Q32 flash. Define FLASH_FASTREAD_EN for 0x0B with
//               eight dummy clocks instead of 0x03.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter #(
    parameter int HALFDIV = 2,
    parameter int LEN_W   = 12,
    parameter int TCSH    = 4
) (
    input  logic             MCLK,
    input  logic             nRESET,
    input  logic             REQ0,
    input  logic [23:0]      ADDR0,
    input  logic [LEN_W-1:0] LEN0,
    output logic             GNT0,
    input  logic             REQ1,
    input  logic [23:0]      ADDR1,
    input  logic [LEN_W-1:0] LEN1,
    output logic             GNT1,
    output logic [7:0]       RDATA,
    output logic             RVALID,
    output logic             RSEL,
    output logic             DONE,
    output logic             BUSY,
    output logic             nCS,
    output logic             MOSI,
    input  logic             MISO,
    output logic             SCLK
);

    localparam int c_div_w = (HALFDIV > 1) ? $clog2(HALFDIV) : 1;
    localparam int c_csh_w = (TCSH > 1) ? $clog2(TCSH) : 1;
`ifdef FLASH_FASTREAD_EN
    localparam logic [7:0] c_opcode = 8'h0B;
`else
    localparam logic [7:0] c_opcode = 8'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
`ifdef FLASH_FASTREAD_EN
        S_DUMMY = 3'd3,
`endif
        S_DATA  = 3'd4,
        S_DESEL = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [c_div_w-1:0] div_q, div_d;
    logic [c_csh_w-1:0] csh_q, csh_d;
    logic [4:0]         bit_q, bit_d;
    logic [LEN_W-1:0]   byte_q, byte_d;
    logic [31:0]        tx_q, tx_d;
    logic [6:0]         rx_q, rx_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               sclk_q, sclk_d;
    logic               ncs_q, ncs_d;
    logic               rvalid_q, rvalid_d;
    logic               rsel_q, rsel_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               w_tick;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        csh_d    = csh_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        sclk_d   = sclk_q;
        ncs_d    = ncs_q;
        rvalid_d = 1'b0;
        rsel_d   = rsel_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        w_tick   = (div_q == c_div_w'(HALFDIV - 1));

        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    gnt0_d  = REQ0;
                    gnt1_d  = !REQ0;
                    rsel_d  = !REQ0;
                    tx_d    = {c_opcode, (REQ0 ? ADDR0 : ADDR1)};
                    byte_d  = REQ0 ? LEN0 : LEN1;
                    bit_d   = 5'd7;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_CMD, S_ADDR,
`ifdef FLASH_FASTREAD_EN
            S_DUMMY,
`endif
            S_DATA: begin
                div_d = w_tick ? '0 : div_q + 1'b1;
                if (w_tick && !sclk_q) begin
                    sclk_d = 1'b1;
                    if (state_q == S_DATA) begin
                        rx_d = {rx_q[5:0], MISO};
                        if (bit_q == 5'd0) begin
                            rdata_d  = {rx_q, MISO};
                            rvalid_d = 1'b1;
                        end
                    end
                end else if (w_tick) begin
                    // Falling edge: shift out next bit; zeros fill in after the address
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[30:0], 1'b0};
                    bit_d  = bit_q - 5'd1;
                    if (bit_q == 5'd0) begin
                        bit_d = 5'd7;
                        case (state_q)
                            S_CMD: begin
                                state_d = S_ADDR;
                                bit_d   = 5'd23;
                            end
`ifdef FLASH_FASTREAD_EN
                            S_ADDR:  state_d = S_DUMMY;
                            S_DUMMY: state_d = S_DATA;
`else
                            S_ADDR:  state_d = S_DATA;
`endif
                            default: begin
                                if (byte_q == '0) begin
                                    state_d = S_DESEL;
                                    ncs_d   = 1'b1;
                                    csh_d   = c_csh_w'(TCSH - 1);
                                end else begin
                                    byte_d = byte_q - 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            S_DESEL: begin
                if (csh_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    csh_d = csh_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ncs_d   = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            csh_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            sclk_q   <= 1'b0;
            ncs_q    <= 1'b1;
            rvalid_q <= 1'b0;
            rsel_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            csh_q    <= csh_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            sclk_q   <= sclk_d;
            ncs_q    <= ncs_d;
            rvalid_q <= rvalid_d;
            rsel_q   <= rsel_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
        end
    end

    assign GNT0   = gnt0_q;
    assign GNT1   = gnt1_q;
    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;
    assign RSEL   = rsel_q;
    assign DONE   = done_q;
    assign BUSY   = busy_q;
    assign nCS    = ncs_q;
    assign MOSI   = tx_q[31];
    assign SCLK   = sclk_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_arbiter
// Description : Directed bench for spi_flash_arbiter with a behavioural flash
//               whose byte at address a is a[7:0]^8'hA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_arbiter;

`ifdef FLASH_FASTREAD_EN
    localparam int         DUM    = 8;
    localparam logic [7:0] OPC    = 8'h0B;
    localparam int         LAT_1B = 196;
    localparam int         LAT_2B = 228;
    localparam int         LAT_3B = 260;
    localparam int         LAT_4B = 292;
`else
    localparam int         DUM    = 0;
    localparam logic [7:0] OPC    = 8'h03;
    localparam int         LAT_1B = 164;
    localparam int         LAT_2B = 196;
    localparam int         LAT_3B = 228;
    localparam int         LAT_4B = 260;
`endif

    logic        MCLK = 1'b0;
    logic        nRESET, REQ0, REQ1;
    logic [23:0] ADDR0, ADDR1;
    logic [11:0] LEN0, LEN1;
    logic        GNT0, GNT1, RVALID, RSEL, DONE, BUSY, nCS, MOSI, SCLK;
    logic [7:0]  RDATA;
    logic        MISO = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    spi_flash_arbiter u_dut (
        .MCLK   (MCLK),   .nRESET (nRESET),
        .REQ0   (REQ0),   .ADDR0  (ADDR0),  .LEN0 (LEN0), .GNT0 (GNT0),
        .REQ1   (REQ1),   .ADDR1  (ADDR1),  .LEN1 (LEN1), .GNT1 (GNT1),
        .RDATA  (RDATA),  .RVALID (RVALID), .RSEL (RSEL), .DONE (DONE),
        .BUSY   (BUSY),   .nCS    (nCS),    .MOSI (MOSI), .MISO (MISO),
        .SCLK   (SCLK)
    );

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    // Flash model, sampled on the falling MCLK edge
    logic        f_sclk_p   = 1'b0;
    int          f_cnt      = 0;
    logic [31:0] f_sh       = '0;
    logic [31:0] f_cmdaddr  = '0;
    int          f_mosi_err = 0;

    function automatic logic flash_bit(input logic [23:0] base, input int idx);
        logic [23:0] a;
        logic [7:0]  b;
        a = (base + 24'(idx / 8)) & 24'h3FFFFF;
        b = a[7:0] ^ 8'hA5;
        return b[3'(7 - (idx % 8))];
    endfunction

    always @(negedge MCLK) begin
        f_sclk_p <= SCLK;
        if (nCS) begin
            f_cnt <= 0;
        end else if (SCLK && !f_sclk_p) begin
            if (f_cnt < 32) f_sh <= {f_sh[30:0], MOSI};
            else if (MOSI) f_mosi_err <= f_mosi_err + 1;
            if (f_cnt == 31) f_cmdaddr <= {f_sh[30:0], MOSI};
            f_cnt <= f_cnt + 1;
        end else if (!SCLK && f_sclk_p && f_cnt >= 32 + DUM) begin
            MISO <= flash_bit(f_sh[23:0], f_cnt - 32 - DUM);
        end
    end

    // Event monitor
    logic [8:0] rxq[$];
    int done_cnt = 0;
    int ncs_run  = 0;
    int last_run = 0;

    always @(negedge MCLK) begin
        if (RVALID) rxq.push_back({RSEL, RDATA});
        if (DONE) done_cnt <= done_cnt + 1;
        if (nCS) begin
            ncs_run <= ncs_run + 1;
        end else begin
            if (ncs_run != 0) last_run <= ncs_run;
            ncs_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [8:0] exp);
        logic [31:0] got;
        got = 32'hDEAD;
        if (rxq.size() > 0) got = 32'(rxq.pop_front());
        chk(tag, got, 32'(exp));
    endtask

    // which: 0=GNT0, 1=GNT1, 2=DONE
    task automatic wait_sig(input int which, input int limit, output int at);
        logic seen;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge MCLK);
            case (which)
                0:       seen = GNT0;
                1:       seen = GNT1;
                default: seen = DONE;
            endcase
            if (seen) at = cyc;
        end
        if (!seen) chk("wait_timeout", 32'(which), 32'hFFFF);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, g2, d, d2, dc;
        nRESET = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; LEN0 = '0; LEN1 = '0;
        repeat (4) @(negedge MCLK);
        chk("rst_ncs",    32'(nCS),    1);
        chk("rst_sclk",   32'(SCLK),   0);
        chk("rst_mosi",   32'(MOSI),   0);
        chk("rst_busy",   32'(BUSY),   0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_rdata",  32'(RDATA),  0);
        chk("rst_done",   32'(DONE),   0);
        chk("rst_gnt",    32'({GNT0, GNT1}), 0);
        nRESET = 1'b1;
        repeat (3) @(negedge MCLK);

        // Single 4-byte read on port 0
        ADDR0 = 24'h012345; LEN0 = 12'd3; REQ0 = 1'b1;
        wait_sig(0, 10, g);
        REQ0 = 1'b0;
        chk("t1_rsel", 32'(RSEL), 0);
        chk("t1_busy", 32'(BUSY), 1);
        chk("t1_ncs",  32'(nCS),  0);
        wait_sig(2, 2000, d);
        chk("t1_latency", 32'(d - g), 32'(LAT_4B));
        chk("t1_busy_done", 32'(BUSY), 0);
        chk("t1_cmdaddr", f_cmdaddr, {OPC, 24'h012345});
        chk("t1_nbytes", 32'(rxq.size()), 4);
        chk_byte("t1_b0", {1'b0, 8'hE0});
        chk_byte("t1_b1", {1'b0, 8'hE3});
        chk_byte("t1_b2", {1'b0, 8'hE2});
        chk_byte("t1_b3", {1'b0, 8'hED});

        // Simultaneous requests: port 0 wins, port 1 follows after the IDLE cycle
        @(negedge MCLK);
        ADDR0 = 24'h000010; LEN0 = 12'd0;
        ADDR1 = 24'h000020; LEN1 = 12'd1;
        REQ0 = 1'b1; REQ1 = 1'b1;
        wait_sig(0, 10, g);
        chk("t2_gnt1_low", 32'(GNT1), 0);
        REQ0 = 1'b0;
        wait_sig(2, 2000, d);
        chk("t2_lat0", 32'(d - g), 32'(LAT_1B));
        wait_sig(1, 5, g2);
        chk("t2_gnt1_gap", 32'(g2 - d), 1);
        chk("t2_rsel1", 32'(RSEL), 1);
        REQ1 = 1'b0;
        wait_sig(2, 2000, d2);
        chk("t2_lat1", 32'(d2 - g2), 32'(LAT_2B));
        chk_byte("t2_b0", {1'b0, 8'hB5});
        chk_byte("t2_b1", {1'b1, 8'h85});
        chk_byte("t2_b2", {1'b1, 8'h84});

        // Port 0 raised mid-DATA of a port 1 read
        @(negedge MCLK);
        ADDR1 = 24'h000100; LEN1 = 12'd2; REQ1 = 1'b1;
        wait_sig(1, 10, g);
        REQ1 = 1'b0;
        repeat (200) @(negedge MCLK);
        ADDR0 = 24'h000200; LEN0 = 12'd0; REQ0 = 1'b1;
        wait_sig(2, 2000, d);
        chk("t3_lat1", 32'(d - g), 32'(LAT_3B));
        wait_sig(0, 5, g2);
        chk("t3_gnt0_gap", 32'(g2 - d), 1);
        REQ0 = 1'b0;
        wait_sig(2, 2000, d2);
        chk_byte("t3_b0", {1'b1, 8'hA5});
        chk_byte("t3_b1", {1'b1, 8'hA4});
        chk_byte("t3_b2", {1'b1, 8'hA7});
        chk_byte("t3_b3", {1'b0, 8'hA5});

        // Minimum transfer at top of flash, then an immediately pending request
        @(negedge MCLK);
        ADDR1 = 24'h3FFFFF; LEN1 = 12'd0; REQ1 = 1'b1;
        wait_sig(1, 10, g);
        REQ1 = 1'b0;
        ADDR0 = 24'h000040; LEN0 = 12'd0; REQ0 = 1'b1;
        wait_sig(2, 2000, d);
        chk("t4_lat", 32'(d - g), 32'(LAT_1B));
        chk("t4_nbytes", 32'(rxq.size()), 1);
        chk_byte("t4_b0", {1'b1, 8'h5A});
        chk("t4_cmdaddr", f_cmdaddr, {OPC, 24'h3FFFFF});
        wait_sig(0, 5, g2);
        REQ0 = 1'b0;
        wait_sig(2, 2000, d2);
        chk("t4_ncs_gap_ok", 32'(last_run >= 4), 1);
        chk_byte("t4_b1", {1'b0, 8'hE5});

        // Reset during ADDR bit 10
        @(negedge MCLK);
        ADDR0 = 24'hABCDEF; LEN0 = 12'd3; REQ0 = 1'b1;
        wait_sig(0, 10, g);
        REQ0 = 1'b0;
        dc = done_cnt;
        repeat (74) @(negedge MCLK);
        nRESET = 1'b0;
        @(negedge MCLK);
        chk("t5_ncs",  32'(nCS),  1);
        chk("t5_sclk", 32'(SCLK), 0);
        chk("t5_busy", 32'(BUSY), 0);
        repeat (4) @(negedge MCLK);
        nRESET = 1'b1;
        repeat (10) @(negedge MCLK);
        chk("t5_no_done", 32'(done_cnt - dc), 0);
        chk("t5_no_bytes", 32'(rxq.size()), 0);
        ADDR0 = 24'h000005; LEN0 = 12'd1; REQ0 = 1'b1;
        wait_sig(0, 10, g);
        REQ0 = 1'b0;
        wait_sig(2, 2000, d);
        chk("t5_lat", 32'(d - g), 32'(LAT_2B));
        chk("t5_cmdaddr", f_cmdaddr, {OPC, 24'h000005});
        chk_byte("t5_b0", {1'b0, 8'hA0});
        chk_byte("t5_b1", {1'b0, 8'hA3});
        chk("mosi_zero_in_data", 32'(f_mosi_err), 0);

        repeat (3) @(negedge MCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
